// File: rtl/alu_pkg.sv
// Shared definitions for the single-issue ALU sequencer: opcode/funct encodings,
// instruction field positions, FSM state type and the destination-register decoder.
// No ports; imported by alu_issue_if, alu_regfile and alu_issue.
package alu_pkg;

  // Instruction field bit positions (MIPS I encoding)
  localparam int unsigned OpcodeHi = 31;
  localparam int unsigned OpcodeLo = 26;
  localparam int unsigned RsHi     = 25;
  localparam int unsigned RsLo     = 21;
  localparam int unsigned RtHi     = 20;
  localparam int unsigned RtLo     = 16;
  localparam int unsigned RdHi     = 15;
  localparam int unsigned RdLo     = 11;
  localparam int unsigned FunctHi  = 5;
  localparam int unsigned FunctLo  = 0;

  // Opcodes
  localparam logic [5:0] OpRtype = 6'b000000;
  localparam logic [5:0] OpBeq   = 6'b000100;
  localparam logic [5:0] OpBne   = 6'b000101;
  localparam logic [5:0] OpAddi  = 6'b001000;
  localparam logic [5:0] OpAddiu = 6'b001001;
  localparam logic [5:0] OpSlti  = 6'b001010;
  localparam logic [5:0] OpSltiu = 6'b001011;
  localparam logic [5:0] OpAndi  = 6'b001100;
  localparam logic [5:0] OpOri   = 6'b001101;
  localparam logic [5:0] OpXori  = 6'b001110;
  localparam logic [5:0] OpLw    = 6'b100011;
  localparam logic [5:0] OpSw    = 6'b101011;

  // R-type funct codes; the ALU decodes these, the issuer only forwards them
  localparam logic [5:0] FnAdd  = 6'b100000;
  localparam logic [5:0] FnAddu = 6'b100001;
  localparam logic [5:0] FnSub  = 6'b100010;
  localparam logic [5:0] FnSubu = 6'b100011;
  localparam logic [5:0] FnAnd  = 6'b100100;
  localparam logic [5:0] FnOr   = 6'b100101;
  localparam logic [5:0] FnXor  = 6'b100110;
  localparam logic [5:0] FnNor  = 6'b100111;
  localparam logic [5:0] FnSlt  = 6'b101010;
  localparam logic [5:0] FnSltu = 6'b101011;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRead = 2'd1,
    StExec = 2'd2,
    StWb   = 2'd3
  } state_e;

  // Register written by an instruction; 0 means no write-back.
  function automatic logic [4:0] dest_reg(input logic [31:0] instr);
    logic [4:0] rd;
    rd = 5'd0;
    case (instr[OpcodeHi:OpcodeLo])
      OpRtype: rd = instr[RdHi:RdLo];
      OpAddi, OpAddiu, OpSlti, OpSltiu, OpAndi, OpOri, OpXori: rd = instr[RtHi:RtLo];
      default: rd = 5'd0;
    endcase
    return rd;
  endfunction

  function automatic logic is_branch(input logic [31:0] instr);
    return (instr[OpcodeHi:OpcodeLo] == OpBeq) || (instr[OpcodeHi:OpcodeLo] == OpBne);
  endfunction

endpackage

// File: rtl/alu_issue_if.sv
// Bus between the issuer and its environment: instruction handshake, ALU operand/result
// exchange, retire report and the debug register-file read port.
// master: environment side (drives instruction, ALU result/flags, dbg address).
// slave : issuer side (drives ready, ALU operands, retire report, dbg data).
interface alu_issue_if #(
  parameter int unsigned XLEN = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     in_instr;
  logic [31:0]     alu_instr;
  logic [XLEN-1:0] alu_rega;
  logic [XLEN-1:0] alu_regb;
  logic [XLEN-1:0] alu_result;
  logic [2:0]      alu_flags;
  logic            done_valid;
  logic [4:0]      done_rd;
  logic [XLEN-1:0] done_data;
  logic            branch_taken;
  logic [XLEN-1:0] branch_offset;
  logic [2:0]      flags_q;
  logic [4:0]      dbg_addr;
  logic [XLEN-1:0] dbg_data;

  modport master (
    output in_valid, in_instr, alu_result, alu_flags, dbg_addr,
    input  in_ready, alu_instr, alu_rega, alu_regb, done_valid, done_rd, done_data,
           branch_taken, branch_offset, flags_q, dbg_data
  );

  modport slave (
    input  in_valid, in_instr, alu_result, alu_flags, dbg_addr,
    output in_ready, alu_instr, alu_rega, alu_regb, done_valid, done_rd, done_data,
           branch_taken, branch_offset, flags_q, dbg_data
  );
endinterface

// File: rtl/alu_regfile.sv
// Register file: two operand read ports, one write port and a debug read port.
// All reads are combinational; r0 always reads 0 and writes to it are dropped.
// Ports: clk, rst_n (async clear of every register), ra_addr/ra_data, rb_addr/rb_data,
//        wr_en/wr_addr/wr_data, dbg_addr/dbg_data.
module alu_regfile #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned NREG = 32,
  localparam int unsigned AW  = $clog2(NREG)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [AW-1:0]   ra_addr,
  output logic [XLEN-1:0] ra_data,
  input  logic [AW-1:0]   rb_addr,
  output logic [XLEN-1:0] rb_data,
  input  logic            wr_en,
  input  logic [AW-1:0]   wr_addr,
  input  logic [XLEN-1:0] wr_data,
  input  logic [AW-1:0]   dbg_addr,
  output logic [XLEN-1:0] dbg_data
);

  logic [XLEN-1:0] regs_q [NREG];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(NREG); i++) begin
        regs_q[i] <= '0;
      end
    end else if (wr_en && (wr_addr != '0)) begin
      regs_q[wr_addr] <= wr_data;
    end
  end

  always_comb begin
    ra_data  = (ra_addr == '0) ? '0 : regs_q[ra_addr];
    rb_data  = (rb_addr == '0) ? '0 : regs_q[rb_addr];
    dbg_data = (dbg_addr == '0) ? '0 : regs_q[dbg_addr];
  end

endmodule

// File: rtl/alu_issue.sv
// Single-issue ALU sequencer. Accepts one MIPS instruction at a time, reads its rs/rt
// operands, hands them to an external ALU, captures the result and writes it back.
// Sequence: IDLE -(handshake)-> READ -> EXEC -> WB -> IDLE; done_valid pulses in WB and
// the register write lands on the WB->IDLE edge.
// Ports: clk, rst_n (async, active-low; aborts any instruction in flight),
//        bus (alu_issue_if.slave): instruction handshake, ALU operands/result,
//        retire report (done_*, branch_*, flags_q) and the debug read port.
module alu_issue
  import alu_pkg::*;
#(
  parameter int unsigned XLEN = 32,
  parameter int unsigned NREG = 32
) (
  input logic         clk,
  input logic         rst_n,
  alu_issue_if.slave  bus
);

  state_e          state_q;
  logic [31:0]     instr_q;
  logic [XLEN-1:0] rega_q;
  logic [XLEN-1:0] regb_q;
  logic            done_valid_q;
  logic [4:0]      done_rd_q;
  logic [XLEN-1:0] done_data_q;
  logic            taken_q;
  logic [XLEN-1:0] offset_q;
  logic [2:0]      flags_r;

  logic [XLEN-1:0] rs_data;
  logic [XLEN-1:0] rt_data;
  logic            wr_en;

  // Write-back uses the values captured at EXEC->WB, so it commits on the WB->IDLE edge.
  assign wr_en = (state_q == StWb);

  alu_regfile #(
    .XLEN(XLEN),
    .NREG(NREG)
  ) u_regfile (
    .clk     (clk),
    .rst_n   (rst_n),
    .ra_addr (instr_q[RsHi:RsLo]),
    .ra_data (rs_data),
    .rb_addr (instr_q[RtHi:RtLo]),
    .rb_data (rt_data),
    .wr_en   (wr_en),
    .wr_addr (done_rd_q),
    .wr_data (done_data_q),
    .dbg_addr(bus.dbg_addr),
    .dbg_data(bus.dbg_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      instr_q      <= '0;
      rega_q       <= '0;
      regb_q       <= '0;
      done_valid_q <= 1'b0;
      done_rd_q    <= '0;
      done_data_q  <= '0;
      taken_q      <= 1'b0;
      offset_q     <= '0;
      flags_r      <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (bus.in_valid) begin
            instr_q <= bus.in_instr;
            state_q <= StRead;
          end
        end
        StRead: begin
          rega_q  <= rs_data;
          regb_q  <= rt_data;
          state_q <= StExec;
        end
        StExec: begin
          done_valid_q <= 1'b1;
          done_rd_q    <= dest_reg(instr_q);
          done_data_q  <= bus.alu_result;
          offset_q     <= bus.alu_result;
          flags_r      <= bus.alu_flags;
          taken_q      <= is_branch(instr_q) & bus.alu_flags[0];
          state_q      <= StWb;
        end
        StWb: begin
          done_valid_q <= 1'b0;
          taken_q      <= 1'b0;
          state_q      <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  always_comb begin
    bus.in_ready      = (state_q == StIdle);
    bus.alu_instr     = instr_q;
    bus.alu_rega      = rega_q;
    bus.alu_regb      = regb_q;
    bus.done_valid    = done_valid_q;
    bus.done_rd       = done_rd_q;
    bus.done_data     = done_data_q;
    bus.branch_taken  = taken_q;
    bus.branch_offset = offset_q;
    bus.flags_q       = flags_r;
  end

endmodule

// File: tb/tb_alu_issue.sv
// Scoreboard bench for alu_issue: directed instructions push hand-computed retire
// reports; an independent negedge monitor pops and compares on every done_valid.
module tb_alu_issue;

  logic clk;
  logic rst_n;
  int   cyc;
  int   errors;
  int   checks;

  alu_issue_if #(.XLEN(32)) bus ();

  alu_issue #(
    .XLEN(32),
    .NREG(32)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Simple external ALU: add/addi-style sum, beq/bne produce offset imm<<2 and
  // report taken in flags[0].
  logic [5:0]  alu_op;
  logic [31:0] alu_simm;
  logic [31:0] alu_diff;
  always_comb begin
    alu_op   = bus.alu_instr[31:26];
    alu_simm = {{16{bus.alu_instr[15]}}, bus.alu_instr[15:0]};
    alu_diff = bus.alu_rega - bus.alu_regb;
    bus.alu_result = '0;
    bus.alu_flags  = '0;
    if (alu_op == 6'b000000) begin
      bus.alu_result = bus.alu_rega + bus.alu_regb;
      bus.alu_flags  = {1'b0, bus.alu_result[31], bus.alu_result == 32'd0};
    end else if (alu_op == 6'b000100 || alu_op == 6'b000101) begin
      bus.alu_result = alu_simm << 2;
      bus.alu_flags  = {2'b00, (alu_op == 6'b000100) ? (alu_diff == 0) : (alu_diff != 0)};
    end else begin
      bus.alu_result = bus.alu_rega + alu_simm;
      bus.alu_flags  = {1'b0, bus.alu_result[31], bus.alu_result == 32'd0};
    end
  end

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
    logic        taken;
    logic        chk_off;
    logic [31:0] off;
    logic [2:0]  flags;
    int          hs;
  } exp_t;

  exp_t sb[$];
  int   accepts[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: compare every retire against the oldest expectation.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && bus.done_valid) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_retire: got done_rd=%0d with nothing outstanding",
                   bus.done_rd);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("latency", cyc - e.hs, 2);
          check("done_rd", {27'd0, bus.done_rd}, {27'd0, e.rd});
          check("done_data", bus.done_data, e.data);
          check("branch_taken", {31'd0, bus.branch_taken}, {31'd0, e.taken});
          check("flags_q", {29'd0, bus.flags_q}, {29'd0, e.flags});
          if (e.chk_off) check("branch_offset", bus.branch_offset, e.off);
        end
      end else begin
        check("taken_outside_wb", {31'd0, bus.branch_taken}, 32'd0);
      end
    end
  end

  task automatic push_exp(input logic [4:0] rd, input logic [31:0] data, input logic taken,
                          input logic chk_off, input logic [2:0] flags);
    exp_t e;
    e.rd = rd; e.data = data; e.taken = taken; e.chk_off = chk_off;
    e.off = data; e.flags = flags; e.hs = cyc + 1;
    sb.push_back(e);
  endtask

  task automatic issue(input logic [31:0] instr, input logic [4:0] rd, input logic [31:0] data,
                       input logic taken, input logic chk_off, input logic [2:0] flags);
    int n;
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_instr = instr;
    n = 0;
    while (!bus.in_ready && n < 10) begin
      @(negedge clk);
      n++;
    end
    check("ready_wait", {31'd0, bus.in_ready}, 32'd1);
    push_exp(rd, data, taken, chk_off, flags);
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 30) begin
      @(negedge clk);
      #1 n++;
    end
    check("drain", sb.size(), 0);
    @(negedge clk);
  endtask

  task automatic dbg(input logic [4:0] a, input logic [31:0] exp);
    @(negedge clk);
    bus.dbg_addr = a;
    #1 check($sformatf("dbg_r%0d", a), bus.dbg_data, exp);
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst_n = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_instr = '0;
    bus.dbg_addr = '0;
    #12;
    check("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
    check("rst_done_valid", {31'd0, bus.done_valid}, 32'd0);
    check("rst_alu_instr", bus.alu_instr, 32'd0);
    check("rst_rega", bus.alu_rega, 32'd0);
    check("rst_regb", bus.alu_regb, 32'd0);
    check("rst_done_rd", {27'd0, bus.done_rd}, 32'd0);
    check("rst_done_data", bus.done_data, 32'd0);
    check("rst_offset", bus.branch_offset, 32'd0);
    check("rst_flags", {29'd0, bus.flags_q}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 32; i++) dbg(i[4:0], 32'd0);

    // addi r1,r0,5
    issue(32'h20010005, 5'd1, 32'd5, 1'b0, 1'b0, 3'b000);
    drain();
    dbg(5'd1, 32'd5);
    // addi r2,r0,7 ; add r3,r1,r2
    issue(32'h20020007, 5'd2, 32'd7, 1'b0, 1'b0, 3'b000);
    issue(32'h00221820, 5'd3, 32'd12, 1'b0, 1'b0, 3'b000);
    drain();
    dbg(5'd3, 32'd12);
    // addi r0,r0,9: reported as no write, r0 stays 0
    issue(32'h20000009, 5'd0, 32'd9, 1'b0, 1'b0, 3'b000);
    drain();
    dbg(5'd0, 32'd0);
    // beq r1,r1,3: taken, offset 12, no register change
    issue(32'h10210003, 5'd0, 32'd12, 1'b1, 1'b1, 3'b001);
    drain();
    dbg(5'd1, 32'd5);
    dbg(5'd2, 32'd7);
    dbg(5'd3, 32'd12);
    // addi r5,r0,-1: negative flag
    issue(32'h2005FFFF, 5'd5, 32'hFFFF_FFFF, 1'b0, 1'b0, 3'b010);
    drain();
    dbg(5'd5, 32'hFFFF_FFFF);
    // lw r2,4(r1): no write-back, done_data is the address 9
    issue(32'h8C220004, 5'd0, 32'd9, 1'b0, 1'b0, 3'b000);
    drain();
    dbg(5'd2, 32'd7);

    // in_valid held high: one accept every 4 cycles (addi r6,r0,1)
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_instr = 32'h20060001;
    for (int i = 0; i < 12; i++) begin
      if (bus.in_ready) begin
        push_exp(5'd6, 32'd1, 1'b0, 1'b0, 3'b000);
        accepts.push_back(cyc + 1);
      end
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    check("accept_count", accepts.size(), 3);
    if (accepts.size() == 3) begin
      check("accept_gap0", accepts[1] - accepts[0], 4);
      check("accept_gap1", accepts[2] - accepts[1], 4);
    end
    drain();
    dbg(5'd6, 32'd1);

    // Reset during EXEC: addi r7,r0,3 must never retire or write
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_instr = 32'h20070003;
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1 check("abort_done_valid", {31'd0, bus.done_valid}, 32'd0);
    check("abort_in_ready", {31'd0, bus.in_ready}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    for (int i = 0; i < 32; i++) dbg(i[4:0], 32'd0);
    check("abort_done_rd", {27'd0, bus.done_rd}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
